// File: rtl/str_acq_ctrl.sv
// rtl/str_acq_ctrl.sv - acquisition sequencer: settle flush, framed capture, drain to DMA
module str_acq_ctrl #(
    parameter int DW        = 24,
    parameter int FRAME_LEN = 16000,
    parameter int SETTLE    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [15:0]   num_frames,
    output logic          adc_en,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    localparam int SW = $clog2(SETTLE) + 1;
    localparam int CW = $clog2(FRAME_LEN) + 1;
    localparam int FW = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [SW-1:0] settle_cnt;
    logic [CW-1:0] sample_cnt;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_cnt_inc;
    logic [15:0]   frames_lat;
    logic          pend_stop;

    logic          start_ok;
    logic          settle_last;
    logic          sample_last;
    logic          cap_rdy;
    logic          cap_acc;
    logic          frames_met;
    logic          to_drain;

    assign start_ok      = start && !stop;
    assign settle_last   = (settle_cnt == SW'(SETTLE - 1));
    assign sample_last   = (sample_cnt == CW'(FRAME_LEN - 1));
    assign cap_rdy       = !m_axis_tvalid || m_axis_tready;
    assign cap_acc       = (state == ST_CAPTURE) && s_axis_tvalid && cap_rdy;
    // Continuous mode may run past 2^17 frames; saturate instead of wrapping.
    assign frame_cnt_inc = (&frame_cnt) ? frame_cnt : frame_cnt + 1'b1;
    assign frames_met    = (frames_lat != 16'd0) && (frame_cnt_inc == {1'b0, frames_lat});
    assign to_drain      = cap_acc && sample_last && (pend_stop || stop || frames_met);
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        adc_en        = 1'b0;
        s_axis_tready = 1'b0;
        case (state)
            ST_IDLE: begin
                s_axis_tready = 1'b1;
                if (start_ok) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                adc_en        = 1'b1;
                s_axis_tready = 1'b1;
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (s_axis_tvalid && settle_last) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                adc_en        = 1'b1;
                s_axis_tready = cap_rdy;
                if (to_drain) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt    <= '0;
            sample_cnt    <= '0;
            frame_cnt     <= '0;
            frames_lat    <= '0;
            pend_stop     <= 1'b0;
            overrun       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        frames_lat <= num_frames;
                        overrun    <= 1'b0;
                        frame_cnt  <= '0;
                        settle_cnt <= '0;
                        sample_cnt <= '0;
                        pend_stop  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (!stop && s_axis_tvalid) begin
                        if (settle_last) begin
                            sample_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (stop) begin
                        pend_stop <= 1'b1;
                    end
                    if (s_axis_tvalid && !cap_rdy) begin
                        overrun <= 1'b1;
                    end
                    if (cap_acc) begin
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= sample_last;
                        if (sample_last) begin
                            sample_cnt <= '0;
                            frame_cnt  <= frame_cnt_inc;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end else if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                    end
                end
                default: begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_str_acq_ctrl.sv
// tb/tb_str_acq_ctrl.sv - directed vector and sequence bench for str_acq_ctrl
module tb_str_acq_ctrl;

    localparam int DW = 16;
    localparam int FL = 8;
    localparam int ST = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [15:0]   num_frames;
    logic          adc_en;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;
    logic          overrun;

    int n_chk  = 0;
    int n_fail = 0;

    str_acq_ctrl #(.DW(DW), .FRAME_LEN(FL), .SETTLE(ST)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .num_frames    (num_frames),
        .adc_en        (adc_en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic start;
        logic stop;
        logic s_tvalid;
        logic m_tready;
        logic busy;
        logic adc_en;
        logic s_tready;
        logic m_tvalid;
        logic done;
        logic overrun;
    } vec_t;

    vec_t vecs[8];

    // Drives one acquisition and scores every output handshake against the
    // source index: output beat k must carry source beat SETTLE+k.
    task automatic run_acq(input string name, input int nf, input bit toggle,
                           input int stop_at, input int start_at, input int rst_at,
                           input int exp_total, input logic exp_ovr, input int base);
        int src = 0;
        int outc = 0;
        int donec = 0;
        int done_cyc = 0;
        bit saw_done = 0;
        bit stop_req = 0;
        bit start_sent = 0;
        bit rst_hit = 0;
        logic stalled = 0;
        logic [DW-1:0] hold_d = '0;
        logic hold_l = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            num_frames    = 16'(nf);
            start         = 1'b0;
            if (cyc == 0) begin
                start = 1'b1;
            end else if (start_at > 0 && outc == start_at && !start_sent) begin
                start      = 1'b1;
                start_sent = 1;
            end
            stop          = stop_req;
            stop_req      = 0;
            s_axis_tvalid = (cyc > 0) && !saw_done;
            s_axis_tdata  = DW'(base + src);
            m_axis_tready = toggle ? ((cyc % 2) == 1) : 1'b1;
            #1;
            if (rst_at > 0 && m_axis_tvalid && outc == rst_at - 1) begin
                rst_n = 1'b0;
                #1;
                chk({name, "_rst_adc_en"}, 32'(adc_en), 0);
                chk({name, "_rst_tvalid"}, 32'(m_axis_tvalid), 0);
                chk({name, "_rst_tlast"}, 32'(m_axis_tlast), 0);
                chk({name, "_rst_tdata"}, 32'(m_axis_tdata), 0);
                chk({name, "_rst_busy"}, 32'(busy), 0);
                chk({name, "_rst_done"}, 32'(done), 0);
                chk({name, "_rst_overrun"}, 32'(overrun), 0);
                rst_hit = 1;
                break;
            end
            if (stalled) begin
                chk({name, "_stall_tvalid"}, 32'(m_axis_tvalid), 1);
                chk({name, "_stall_tdata"}, 32'(m_axis_tdata), 32'(hold_d));
                chk({name, "_stall_tlast"}, 32'(m_axis_tlast), 32'(hold_l));
            end
            if (s_axis_tvalid && s_axis_tready) begin
                src++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                chk($sformatf("%s_data%0d", name, outc), 32'(m_axis_tdata), 32'((base + ST + outc) & 16'hFFFF));
                chk($sformatf("%s_tlast%0d", name, outc), 32'(m_axis_tlast), 32'((outc % FL) == FL - 1));
                if (outc + 1 == exp_total) begin
                    chk({name, "_drain_adc_en"}, 32'(adc_en), 0);
                    chk({name, "_drain_s_tready"}, 32'(s_axis_tready), 0);
                end
                outc++;
                if (stop_at > 0 && outc == stop_at) begin
                    stop_req = 1;
                end
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            hold_d  = m_axis_tdata;
            hold_l  = m_axis_tlast;
            if (done) begin
                donec++;
                if (!saw_done) begin
                    saw_done = 1;
                    done_cyc = cyc;
                end
            end
            if (saw_done && cyc >= done_cyc + 3) begin
                break;
            end
        end
        start         = 1'b0;
        stop          = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        if (!rst_hit) begin
            chk({name, "_beats"}, 32'(outc), 32'(exp_total));
            chk({name, "_done_pulses"}, 32'(donec), 1);
            chk({name, "_busy_end"}, 32'(busy), 0);
            chk({name, "_overrun"}, 32'(overrun), 32'(exp_ovr));
        end else begin
            chk({name, "_reset_reached"}, 32'(rst_hit), 1);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        num_frames    = 16'd0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;

        //            start stop vld rdy | busy adc str mv done ovr
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_adc_en", 32'(adc_en), 0);
        chk("reset_tvalid", 32'(m_axis_tvalid), 0);
        chk("reset_tlast", 32'(m_axis_tlast), 0);
        chk("reset_tdata", 32'(m_axis_tdata), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_overrun", 32'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start         = vecs[i].start;
            stop          = vecs[i].stop;
            s_axis_tvalid = vecs[i].s_tvalid;
            s_axis_tdata  = DW'(16'h0E00 + i);
            m_axis_tready = vecs[i].m_tready;
            #1;
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_adc_en", i), 32'(adc_en), 32'(vecs[i].adc_en));
            chk($sformatf("vec%0d_s_tready", i), 32'(s_axis_tready), 32'(vecs[i].s_tready));
            chk($sformatf("vec%0d_m_tvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].m_tvalid));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].overrun));
        end
        start         = 1'b0;
        stop          = 1'b0;
        s_axis_tvalid = 1'b0;

        run_acq("two_frames", 2, 1'b0, 0, 0, 0, 16, 1'b0, 16'h1000);
        run_acq("stop_cont", 0, 1'b0, 3, 0, 0, 8, 1'b0, 16'h2000);
        run_acq("stall", 2, 1'b1, 0, 0, 0, 16, 1'b1, 16'h3000);
        run_acq("start_ign", 2, 1'b0, 0, 5, 0, 16, 1'b0, 16'h4000);
        run_acq("mid_reset", 2, 1'b0, 0, 0, 5, 16, 1'b0, 16'h6000);

        @(negedge clk);
        rst_n      = 1'b1;
        num_frames = 16'd1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("post_rst_start_busy", 32'(busy), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1;
        chk("post_rst_stop_done", 32'(done), 1);
        chk("post_rst_stop_busy", 32'(busy), 0);

        run_acq("post_rst_frame", 1, 1'b0, 0, 0, 0, 8, 1'b0, 16'h5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/str_acq_ctrl.md
STR_ACQ_CTRL -- requirements
Module: str_acq_ctrl

Interface
REQ-001 Parameter DW, default 24, sample width of the down-sampled stream.
REQ-002 Parameter FRAME_LEN, default 16000, output samples per frame; legal range 2..65535.
REQ-003 Parameter SETTLE, default 64, samples discarded after start to flush filter pipelines; legal range 1..65535.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle pulse that begins an acquisition.
REQ-007 stop  input  1  single-cycle pulse that ends the acquisition at the next frame boundary.
REQ-008 num_frames  input  16  frames per acquisition, sampled on accepted start; 0 means continuous.
REQ-009 adc_en  output  1  enables the upstream ADC and decimation chain.
REQ-010 s_axis_tdata / s_axis_tvalid / s_axis_tready  input DW / input 1 / output 1  stream from the decimation chain.
REQ-011 m_axis_tdata / m_axis_tvalid / m_axis_tready / m_axis_tlast  output DW / output 1 / input 1 / output 1  framed stream to the DMA.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse when an acquisition returns to IDLE.
REQ-014 overrun  output  1  sticky flag for an upstream sample lost during CAPTURE.

Function
REQ-015 States are IDLE, SETTLE, CAPTURE and DRAIN, held in registers.
REQ-016 IDLE: adc_en=0, s_axis_tready=1 (discard), m_axis_tvalid=0; start moves to SETTLE, latches num_frames and clears overrun, frame counter and settle counter.
REQ-017 start and stop in the same cycle in IDLE: start is ignored and the state stays IDLE.
REQ-018 start outside IDLE is ignored.
REQ-019 SETTLE: adc_en=1, s_axis_tready=1, and each s_axis_tvalid beat is discarded and counted.
REQ-020 The SETTLE-th discarded beat moves the state to CAPTURE and clears the sample counter.
REQ-021 stop during SETTLE moves the state to IDLE on the next cycle and pulses done.
REQ-022 CAPTURE output register stage: s_axis_tready = !m_axis_tvalid || m_axis_tready.
REQ-023 An accepted input beat appears on m_axis_tdata with m_axis_tvalid=1 on the next cycle (latency 1).
REQ-024 m_axis_tdata, m_axis_tvalid and m_axis_tlast hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 The sample counter increments per accepted input beat, range 0..FRAME_LEN-1.
REQ-026 m_axis_tlast=1 exactly on the beat loaded when the counter is FRAME_LEN-1; the counter then wraps to 0 and the frame counter increments.
REQ-027 stop in CAPTURE sets a pending-stop flag; the frame in progress always completes.
REQ-028 The state moves to DRAIN on the tlast beat when pending-stop is set, or when num_frames is nonzero and the frame counter reaches num_frames.
REQ-029 When the move to DRAIN happens, no further input beats are accepted.
REQ-030 DRAIN: adc_en=0, s_axis_tready=0, wait until the output register empties (tlast handshake), then go to IDLE with done=1 for one cycle.
REQ-031 stop in DRAIN or IDLE has no effect.
REQ-032 overrun is set when s_axis_tvalid=1 and s_axis_tready=0 in CAPTURE; it stays set until the next accepted start.
REQ-033 Counter widths are $clog2 of their maximum plus 1, and no counter wraps except as defined in REQ-026.

Reset
REQ-034 Asserting rst_n low, in any state including mid-frame, immediately forces state IDLE and clears all counters and the pending-stop flag.
REQ-035 While rst_n is low: adc_en=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, overrun=0.
REQ-036 After rst_n deasserts, a start is honoured on the first clock edge.

Verification
REQ-037 FRAME_LEN=8, SETTLE=4, num_frames=2, continuous valid, ready=1 -> first 4 beats dropped; 16 beats out, tlast on output beats 8 and 16; done pulses once; adc_en falls entering DRAIN.
REQ-038 num_frames=0 with stop pulsed at output beat 3 -> output continues to beat 8 with tlast, then DRAIN, IDLE, done.
REQ-039 m_axis_tready toggling 1/0 every cycle in CAPTURE -> no data loss or duplication, payload stable while stalled, overrun set when s_axis_tvalid is held high.
REQ-040 start and stop together in IDLE -> stays IDLE, busy=0; stop in SETTLE -> IDLE with done, zero output beats.
REQ-041 rst_n low at output beat 5 of frame 1 with m_axis_tvalid=1 -> outputs take reset values immediately; a new start gives a full 8-beat frame after 4 settle beats.
REQ-042 start pulsed during CAPTURE -> ignored, and frame and sample counts are unchanged.
